// File: rtl/ripple_cnt_ctrl_pkg.sv
// Shared types and constants for the ripple counter sequencer.
package ripple_cnt_ctrl_pkg;

   // Depth of the synchronizer between the ripple chain and clk.
   localparam int SYNC_STAGES = 2;

   // Width of the shared cycle down-counter used by CLEAR, GAP and SETTLE.
   localparam int CYC_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      CHECK,
      GAP,
      TICK,
      SETTLE,
      DONE
   } state_t;

endpackage

// File: rtl/ripple_cnt_ctrl_if.sv
// Job interface of the ripple counter sequencer: request handshake, abort,
// status and result. The master side issues jobs, the slave side runs them.
interface ripple_cnt_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] target;
   logic [7:0]       gap;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] count_o;
   logic             err_o;

   modport master (
      output start_valid, target, gap, abort,
      input  start_ready, busy, done, count_o, err_o
   );

   modport slave (
      input  start_valid, target, gap, abort,
      output start_ready, busy, done, count_o, err_o
   );
endinterface

// File: rtl/cnt_sync.sv
// Multi-flop synchronizer bringing the asynchronous ripple counter outputs
// into the clk domain. The counter is only sampled after it has settled, so
// a plain per-bit synchronizer is sufficient (no gray coding needed).
module cnt_sync
   import ripple_cnt_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] cnt_q,
   output logic [WIDTH-1:0] sampled
);
   logic [WIDTH-1:0] sync_p [SYNC_STAGES];

   // Shift the raw counter value through the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_p[i] <= '0;
         end
      end else begin
         sync_p[0] <= cnt_q;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_p[i] <= sync_p[i-1];
         end
      end
   end

   assign sampled = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_cnt_ctrl.sv
// Sequencer for an asynchronous D-flip-flop ripple counter. A job clears the
// counter, then repeatedly waits `gap` cycles, fires one tick, waits for the
// ripple to settle and compares the synchronized count with the target.
// Build macro RIPPLE_CNT_CTRL_CHECK_EN adds a shadow counter that flags a
// counter that does not follow the issued ticks (err_o); without it err_o is 0.
module ripple_cnt_ctrl
   import ripple_cnt_ctrl_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int CLR_CYC    = 2,
   parameter int SETTLE_CYC = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   ripple_cnt_ctrl_if.slave job,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_tick,
   output logic             cnt_clr
);
   // Down-counter reload values: a state lasting N cycles loads N-1.
   localparam logic [CYC_W-1:0] CLR_LOAD    = CYC_W'(CLR_CYC - 1);
   localparam logic [CYC_W-1:0] SETTLE_LOAD = CYC_W'(SETTLE_CYC - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CYC_W-1:0] cyc;
   logic [CYC_W-1:0] cyc_nxt;
   logic [WIDTH-1:0] target_r;
   logic [7:0]       gap_r;
   logic [WIDTH-1:0] sampled;
   logic             accept;
   logic             mismatch;

   cnt_sync #(
      .WIDTH(WIDTH)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .cnt_q   (cnt_q),
      .sampled (sampled)
   );

   // abort has priority over a new request, so it gates readiness.
   assign job.start_ready = (state == IDLE) && !job.abort;
   assign job.busy        = (state != IDLE);
   assign accept          = job.start_valid && job.start_ready;

`ifdef RIPPLE_CNT_CTRL_CHECK_EN
   logic [WIDTH-1:0] shadow;
   logic             err;

   assign mismatch  = (state == CHECK) && (sampled != shadow);
   assign job.err_o = err;

   // Shadow count follows the ticks issued; error is sticky until next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         err    <= 1'b0;
      end else begin
         if (state == CLEAR) begin
            shadow <= '0;
         end else if (state == TICK) begin
            shadow <= shadow + 1'b1;
         end
         if (accept) begin
            err <= 1'b0;
         end else if (mismatch) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign mismatch  = 1'b0;
   assign job.err_o = 1'b0;
`endif

   // Job parameters are plain data captured at accept; no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         target_r <= job.target;
         gap_r    <= job.gap;
      end
   end

   // Next-state and cycle down-counter; abort overrides everything but IDLE.
   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc;
      if (cyc != '0) begin
         cyc_nxt = cyc - 1'b1;
      end
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = CLEAR;
               cyc_nxt   = CLR_LOAD;
            end
         end
         CLEAR: begin
            if (cyc == '0) begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (mismatch || (sampled == target_r)) begin
               state_nxt = DONE;
            end else if (gap_r != 8'd0) begin
               state_nxt = GAP;
               cyc_nxt   = gap_r - 8'd1;
            end else begin
               state_nxt = TICK;
            end
         end
         GAP: begin
            if (cyc == '0) begin
               state_nxt = TICK;
            end
         end
         TICK: begin
            state_nxt = SETTLE;
            cyc_nxt   = SETTLE_LOAD;
         end
         SETTLE: begin
            if (cyc == '0) begin
               state_nxt = CHECK;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if ((state != IDLE) && job.abort) begin
         state_nxt = IDLE;
      end
   end

   // State and cycle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cyc   <= '0;
      end else begin
         state <= state_nxt;
         cyc   <= cyc_nxt;
      end
   end

   // Registered outputs: tick/clear drive the ripple chain and must be glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_tick    <= 1'b0;
         cnt_clr     <= 1'b0;
         job.done    <= 1'b0;
         job.count_o <= '0;
      end else begin
         cnt_tick <= (state_nxt == TICK);
         cnt_clr  <= (state_nxt == CLEAR);
         job.done <= (state_nxt == DONE);
         if (state_nxt == DONE) begin
            job.count_o <= sampled;
         end
      end
   end

endmodule
